// File: rtl/sc_pkg.sv
// Shared types and helpers for the stochastic-to-binary stream counter.
// The rescale helper works on a wide container so any W up to 63 fits.
package sc_pkg;

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DONE
    } sc_cnt_state_t;

    localparam int SC_XW = 64;

    function automatic int sc_pw(input int w);
        return $clog2(w + 1);
    endfunction

    function automatic logic [SC_XW-1:0] sc_rescale(
        input logic [SC_XW-1:0] count,
        input int unsigned      p,
        input int unsigned      w
    );
        logic [SC_XW-1:0] sh;
        logic [SC_XW-1:0] lim;
        sh  = count << (w - p);
        lim = (SC_XW'(1) << w) - SC_XW'(1);
        return (sh > lim) ? lim : sh;
    endfunction

endpackage

// File: rtl/sc_ones_counter.sv
// Per-stream ones counter, W+1 bits wide so a full 2^W window fits.
module sc_ones_counter #(
    parameter int W = 8
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       clr,
    input  logic       en,
    input  logic       x,
    output logic [W:0] count,
    output logic [W:0] count_nxt
);

    assign count_nxt = count + {{W{1'b0}}, x};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count <= '0;
        end else if (clr) begin
            count <= '0;
        end else if (en) begin
            count <= count_nxt;
        end
    end

endmodule

// File: rtl/sc_stream_counter.sv
// Counts ones in N unipolar bitstreams over 2^prec accepted samples and
// returns rescaled W-bit binary estimates through a valid/ready handshake.
module sc_stream_counter
    import sc_pkg::*;
#(
    parameter int W  = 8,
    parameter int N  = 4,
    parameter int PW = sc_pw(W)
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          start,
    input  logic [PW-1:0] prec,
    input  logic          in_valid,
    input  logic [N-1:0]  Xs,
    output logic          busy,
    output logic          out_valid,
    input  logic          out_ready,
    output logic [W-1:0]  Zs [N]
);

    sc_cnt_state_t state;
    logic [PW-1:0] p;
    logic [PW-1:0] p_in;
    logic [W:0]    smp_cnt;
    logic [W:0]    ones     [N];
    logic [W:0]    ones_nxt [N];
    logic [W-1:0]  zr       [N];
    logic          clr;
    logic          acc;
    logic          last;

    assign p_in = (prec > PW'(W)) ? PW'(W) : prec;

    // Start in DONE is dropped, so it must not clear the held counts.
    assign clr  = start && (state != DONE);
    assign acc  = (state == RUN) && in_valid && !start;
    assign last = acc && (smp_cnt == (((W+1)'(1) << p) - (W+1)'(1)));

    for (genvar i = 0; i < N; i++) begin : g_cnt
        sc_ones_counter #(
            .W (W)
        ) u_cnt (
            .clk       (clk),
            .rst_n     (rst_n),
            .clr       (clr),
            .en        (acc),
            .x         (Xs[i]),
            .count     (ones[i]),
            .count_nxt (ones_nxt[i])
        );
    end

    always_comb begin
        for (int i = 0; i < N; i++) begin
            zr[i] = W'(sc_rescale(SC_XW'(ones_nxt[i]), 32'(p), W));
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            p         <= '0;
            smp_cnt   <= '0;
            busy      <= 1'b0;
            out_valid <= 1'b0;
            for (int i = 0; i < N; i++) begin
                Zs[i] <= '0;
            end
        end else begin
            unique case (state)
                IDLE: begin
                    if (start) begin
                        state   <= RUN;
                        busy    <= 1'b1;
                        p       <= p_in;
                        smp_cnt <= '0;
                    end
                end
                RUN: begin
                    if (start) begin
                        p       <= p_in;
                        smp_cnt <= '0;
                    end else if (last) begin
                        state     <= DONE;
                        busy      <= 1'b0;
                        out_valid <= 1'b1;
                        for (int i = 0; i < N; i++) begin
                            Zs[i] <= zr[i];
                        end
                    end else if (in_valid) begin
                        smp_cnt <= smp_cnt + (W+1)'(1);
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        state     <= IDLE;
                        out_valid <= 1'b0;
                    end
                end
                default: begin
                    state     <= IDLE;
                    busy      <= 1'b0;
                    out_valid <= 1'b0;
                end
            endcase
        end
    end

endmodule
